// File: rtl/ysyx_23060203_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_pkg
//   Shared types and constants for the ysyx_23060203 core front end.
//   - RESET_PC      : fetch PC loaded when reset is asserted.
//   - FETCH_DEPTH   : default number of fetch queue entries.
//   - fetch_entry_t : one fetched instruction together with its PC.
// ---------------------------------------------------------------------------
package ysyx_23060203_pkg;

    localparam logic [31:0] RESET_PC    = 32'h3000_0000;
    localparam int          FETCH_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ysyx_23060203_sync_fifo.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_sync_fifo
//   Generic single-clock FIFO with a synchronous flush. Used by the fetch
//   queue and by the LSU store buffer.
//   Parameters: DEPTH (power of two, >= 2), T (entry type).
//   Ports:
//     clock, reset  in   clock, synchronous active-high reset
//     push          in   write data at the tail (ignored when full)
//     pop           in   drop the head entry (ignored when empty)
//     flush         in   discard all entries; overrides push and pop
//     data          in   entry written on push
//     full, empty   out  occupancy flags
//     head          out  oldest entry; don't-care when empty
// ---------------------------------------------------------------------------
module ysyx_23060203_sync_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  T     data,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    T              mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full  & ~flush;
    assign do_pop  = pop  & ~empty & ~flush;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers alone decide
    // which slots are live, so this maps onto plain RAM/flops without reset.
    always_ff @(posedge clock) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= data;
        end
    end

endmodule

// File: rtl/ysyx_23060203_fetch_queue.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_fetch_queue
//   Fetch front end ahead of the ICache. Owns the fetch PC, enqueues
//   {pc, inst} on every cache hit and hands queued instructions to the IDU.
//   Redirects (branch/jump/trap/fence.i) flush the queue and reload the PC.
//   Ports:
//     clock, reset     in   clock, synchronous active-high reset
//     redirect_valid   in   redirect request from EXU/WBU
//     redirect_pc      in   new fetch PC (bits [1:0] ignored)
//     fencei           in   fence.i commit, qualified by redirect_valid
//     icache_fencei    out  ICache invalidate
//     icache_addr      out  lookup address (the fetch PC register)
//     icache_hit       in   lookup hit, same cycle
//     icache_inst      in   instruction word on hit
//     out_valid        out  queue head valid
//     out_ready        in   IDU accepts the head
//     out_pc, out_inst out  head entry
// ---------------------------------------------------------------------------
module ysyx_23060203_fetch_queue
    import ysyx_23060203_pkg::*;
#(
    parameter int          DEPTH    = FETCH_DEPTH,
    parameter logic [31:0] RESET_PC = ysyx_23060203_pkg::RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fencei,
    output logic        icache_fencei,
    output logic [31:0] icache_addr,
    input  logic        icache_hit,
    input  logic [31:0] icache_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    logic [31:0]  pc;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

    // Instructions are word aligned, so the low redirect bits carry nothing.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A redirect wins over everything: the queued entries belong to the old
    // path, so neither a push nor a pop may happen in that cycle.
    assign push = icache_hit & ~full & ~redirect_valid;
    assign pop  = out_valid & out_ready & ~redirect_valid;

    assign icache_fencei = fencei & redirect_valid;
    assign icache_addr   = pc;
    assign wr_entry      = '{pc: pc, inst: icache_inst};

    assign out_valid = ~empty;
    assign out_pc    = head.pc;
    assign out_inst  = head.inst;

    // pc + 4 wraps naturally at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    ysyx_23060203_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_queue (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .data  (wr_entry),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

endmodule

// File: tb/tb_ysyx_23060203_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060203_fetch_queue
//   Self-checking bench for ysyx_23060203_fetch_queue: a directed vector
//   table, hand-written multi-cycle sequences, and randomized traffic
//   compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_ysyx_23060203_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fencei;
    logic        icache_fencei;
    logic [31:0] icache_addr;
    logic        icache_hit;
    logic [31:0] icache_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ysyx_23060203_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fencei         (fencei),
        .icache_fencei  (icache_fencei),
        .icache_addr    (icache_addr),
        .icache_hit     (icache_hit),
        .icache_inst    (icache_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 1 more unit later, well away from the next edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Fake ICache: on a hit the instruction word is ~address.
    task automatic drive(input logic rv, input logic [31:0] rpc, input logic fi,
                         input logic hit, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        fencei         = fi;
        icache_hit     = hit;
        out_ready      = rdy;
        icache_inst    = hit ? ~icache_addr : 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        fi;
        logic        hit;
        logic        rdy;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_fencei;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    function automatic vec_t v(input logic rv, input logic [31:0] rpc, input logic fi,
                               input logic hit, input logic rdy, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ep, input logic ef);
        vec_t r;
        r = '{rv, rpc, fi, hit, rdy, ea, ev, ep, ef};
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;

    task automatic model_edge(input logic rst, input logic rv, input logic [31:0] rpc,
                              input logic hit, input logic [31:0] inst, input logic rdy);
        bit was_full;
        if (rst) begin
            mq.delete();
            mpc = RST_PC;
        end else if (rv) begin
            mq.delete();
            mpc = rpc & 32'hFFFF_FFFC;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (hit && !was_full) begin
                mq.push_back('{mpc, inst});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        fencei         = 1'b0;
        icache_hit     = 1'b0;
        icache_inst    = '0;
        out_ready      = 1'b0;

        // ---- reset state ----
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("reset_addr", icache_addr, RST_PC);
        check("reset_valid", {31'b0, out_valid}, 32'd0);
        check("reset_fencei", {31'b0, icache_fencei}, 32'd0);

        // ---- vector table: streaming, miss, redirect, fence.i ----
        //           rv    rpc           fi    hit   rdy   addr          valid pc            fencei
        vecs[0]  = v(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h3000_0000, 1'b0, 32'h0,        1'b0);
        vecs[1]  = v(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h3000_0004, 1'b1, 32'h3000_0000, 1'b0);
        vecs[2]  = v(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h3000_0008, 1'b1, 32'h3000_0004, 1'b0);
        vecs[3]  = v(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h3000_000C, 1'b1, 32'h3000_0008, 1'b0);
        vecs[4]  = v(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h3000_000C, 1'b0, 32'h0,        1'b0);
        vecs[5]  = v(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h3000_000C, 1'b0, 32'h0,        1'b0);
        vecs[6]  = v(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h3000_0010, 1'b1, 32'h3000_000C, 1'b0);
        vecs[7]  = v(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h3000_0014, 1'b1, 32'h3000_000C, 1'b0);
        vecs[8]  = v(1'b1, 32'h8000_0103, 1'b0, 1'b1, 1'b1, 32'h3000_0018, 1'b1, 32'h3000_000C, 1'b0);
        vecs[9]  = v(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'h0,        1'b0);
        vecs[10] = v(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 32'h0,        1'b0);
        vecs[11] = v(1'b1, 32'h3000_0040, 1'b1, 1'b1, 1'b0, 32'h8000_0104, 1'b1, 32'h8000_0100, 1'b1);
        vecs[12] = v(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h3000_0040, 1'b0, 32'h0,        1'b0);
        vecs[13] = v(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h3000_0040, 1'b0, 32'h0,        1'b0);
        vecs[14] = v(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'h3000_0040, 1'b0, 32'h0,        1'b0);
        vecs[15] = v(1'b1, 32'h0000_1002, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0,        1'b0);
        vecs[16] = v(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0000_1000, 1'b0, 32'h0,        1'b0);
        vecs[17] = v(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_1004, 1'b1, 32'h0000_1000, 1'b0);
        vecs[18] = v(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_1004, 1'b0, 32'h0,        1'b0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rv, vecs[i].rpc, vecs[i].fi, vecs[i].hit, vecs[i].rdy);
            check($sformatf("vec%0d_addr", i), icache_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("vec%0d_fencei", i), {31'b0, icache_fencei}, {31'b0, vecs[i].e_fencei});
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_pc", i), out_pc, vecs[i].e_pc);
                check($sformatf("vec%0d_inst", i), out_inst, ~vecs[i].e_pc);
            end
            tick();
        end

        // ---- full: 6 hit cycles with IDU stalled ----
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            check($sformatf("fill%0d_addr", k), icache_addr, RST_PC + 32'd4 * ((k < 4) ? k : 4));
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("full_addr", icache_addr, 32'h3000_0010);
        // drain with no new hits: exactly four entries in order
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            check($sformatf("drain%0d_valid", k), {31'b0, out_valid}, 32'd1);
            check($sformatf("drain%0d_pc", k), out_pc, RST_PC + 32'd4 * k);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("drained_valid", {31'b0, out_valid}, 32'd0);
        check("drained_addr", icache_addr, 32'h3000_0010);

        // refill to full, then pop+hit in one cycle: push must stay blocked
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("fullpop_pc", out_pc, 32'h3000_0010);
        check("fullpop_addr", icache_addr, 32'h3000_0020);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("nobypass_addr", icache_addr, 32'h3000_0020);
        check("nobypass_pc", out_pc, 32'h3000_0014);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("resume_addr", icache_addr, 32'h3000_0024);

        // ---- reset in the middle of traffic ----
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_addr", icache_addr, RST_PC);

        // ---- miss and wrap ----
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            check($sformatf("miss%0d_addr", k), icache_addr, 32'hFFFF_FFFC);
            check($sformatf("miss%0d_valid", k), {31'b0, out_valid}, 32'd0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("wrap_addr", icache_addr, 32'h0000_0000);
        check("wrap_valid", {31'b0, out_valid}, 32'd1);
        check("wrap_pc", out_pc, 32'hFFFF_FFFC);
        check("wrap_inst", out_inst, 32'h0000_0003);

        // ---- randomized traffic vs reference model ----
        do_reset();
        mq.delete();
        mpc = RST_PC;
        for (int n = 0; n < 3000; n++) begin
            logic        r_rst, r_rv, r_fi, r_hit, r_rdy;
            logic [31:0] r_rpc, r_inst;
            r_rst  = ($urandom_range(0, 199) == 0);
            r_rv   = ($urandom_range(0, 15) == 0);
            r_fi   = $urandom_range(0, 1) == 1;
            r_rpc  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom;
            r_hit  = ($urandom_range(0, 3) != 0);
            r_rdy  = $urandom_range(0, 1) == 1;
            r_inst = $urandom;

            reset          = r_rst;
            redirect_valid = r_rv;
            redirect_pc    = r_rpc;
            fencei         = r_fi;
            icache_hit     = r_hit;
            icache_inst    = r_inst;
            out_ready      = r_rdy;
            #1;
            check("rnd_addr", icache_addr, mpc);
            check("rnd_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
            check("rnd_fencei", {31'b0, icache_fencei}, {31'b0, r_fi & r_rv});
            if (mq.size() > 0) begin
                check("rnd_pc", out_pc, mq[0].pc);
                check("rnd_inst", out_inst, mq[0].inst);
            end
            tick();
            model_edge(r_rst, r_rv, r_rpc, r_hit, r_inst, r_rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
